// File: rtl/lvds_frame_rx.sv
// lvds_frame_rx
//   Serial front end of the breakout host link. Assembles WORD_BITS-bit words
//   (MSB first) from the LVDS data line, finds frame alignment from a periodic
//   sync word, holds lock with a flywheel, and emits payload words with their
//   slot index.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   HUNT   | bit-by-bit search for SYNC_WORD; no payload output
//   VERIFY | candidate alignment found; counting correctly spaced syncs
//   LOCKED | aligned; payload emitted, missing syncs counted (flywheel)
//
// Ports
//   clk        in   bit clock, one serial bit per rising edge
//   reset      in   synchronous, active-high
//   din        in   serial data, already synchronised to clk
//   word       out  last emitted payload word (held between strobes)
//   word_valid out  one-cycle strobe; word/word_idx valid
//   word_idx   out  payload slot index 1..FRAME_WORDS-1
//   locked     out  high while in LOCKED
//   sync_err   out  one-cycle pulse on a missing sync word while LOCKED
module lvds_frame_rx #(
  parameter int                   WORD_BITS     = 12,
  parameter int                   FRAME_WORDS   = 4,
  parameter logic [WORD_BITS-1:0] SYNC_WORD     = 12'b000100000000,
  parameter int                   LOCK_MATCHES  = 2,
  parameter int                   UNLOCK_MISSES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic [7:0]           word_idx,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int BC_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int MC_W = $clog2(LOCK_MATCHES + 1);
  localparam int MS_W = $clog2(UNLOCK_MISSES + 1);

  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_BITS - 1);
  localparam logic [7:0]      SLOT_LAST = 8'(FRAME_WORDS - 1);
  localparam logic [MC_W-1:0] LOCK_M    = MC_W'(LOCK_MATCHES);
  localparam logic [MS_W-1:0] UNLOCK_M  = MS_W'(UNLOCK_MISSES);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_e;

  state_e                 state_q, state_d;
  // Only the older WORD_BITS-1 bits are stored; the newest bit is din itself.
  logic [WORD_BITS-2:0]   sr_q;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]             slot_q, slot_d;
  logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
  logic [MS_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic [7:0]             word_idx_q, word_idx_d;
  logic                   word_valid_q, word_valid_d;
  logic                   sync_err_q, sync_err_d;

  logic [WORD_BITS-1:0]   nsr;
  logic                   sync_hit, boundary, slot0_bnd;
  logic [MC_W-1:0]        match_inc;
  logic [MS_W-1:0]        miss_inc;

  assign nsr       = {sr_q, din};
  assign sync_hit  = (nsr == SYNC_WORD);
  assign boundary  = (bit_cnt_q == BIT_LAST);
  assign slot0_bnd = boundary && (slot_q == 8'd0);
  assign match_inc = match_cnt_q + MC_W'(1);
  assign miss_inc  = miss_cnt_q + MS_W'(1);

  // State register (all sequential state, outputs registered for latency 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HUNT;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      slot_q       <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= nsr[WORD_BITS-2:0];
      bit_cnt_q    <= bit_cnt_d;
      slot_q       <= slot_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + BC_W'(1);
    slot_d      = slot_q;
    if (boundary) slot_d = (slot_q == SLOT_LAST) ? 8'd0 : slot_q + 8'd1;

    unique case (state_q)
      S_HUNT: begin
        bit_cnt_d = '0;
        slot_d    = '0;
        if (sync_hit) begin
          // The sync word just completed; next bit is bit 0 of slot 1.
          slot_d      = 8'd1;
          match_cnt_d = MC_W'(1);
          miss_cnt_d  = '0;
          state_d     = (LOCK_MATCHES == 1) ? S_LOCKED : S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (slot0_bnd) begin
          if (sync_hit) begin
            match_cnt_d = match_inc;
            if (match_inc == LOCK_M) begin
              state_d    = S_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = S_HUNT;
          end
        end
      end
      S_LOCKED: begin
        if (slot0_bnd) begin
          if (sync_hit) begin
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_inc;
            if (miss_inc == UNLOCK_M) state_d = S_HUNT;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    word_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    if (state_q == S_LOCKED && boundary) begin
      if (slot_q != 8'd0) begin
        word_d       = nsr;
        word_idx_d   = slot_q;
        word_valid_d = 1'b1;
      end else if (!sync_hit) begin
        sync_err_d = 1'b1;
      end
    end
  end

  assign word       = word_q;
  assign word_idx   = word_idx_q;
  assign word_valid = word_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_lvds_frame_rx.sv
module tb_lvds_frame_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [11:0] word;
  logic        word_valid;
  logic [7:0]  word_idx;
  logic        locked;
  logic        sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int cyc; logic [11:0] w; logic [7:0] idx;} wexp_t;
  typedef struct {int cyc; logic val;} lexp_t;

  wexp_t wq[$];
  int    sq[$];
  lexp_t lq[$];

  bit   mon_en = 1'b0;
  logic prev_locked = 1'b0;

  lvds_frame_rx dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .word       (word),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    wexp_t we;
    lexp_t le;
    int    sc;
    if (mon_en) begin
      if (word_valid !== 1'b0) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL word_strobe: unexpected strobe word=%h idx=%0d valid=%b at cyc %0d",
                   word, word_idx, word_valid, cyc);
        end else begin
          we = wq.pop_front();
          if (word !== we.w || word_idx !== we.idx || cyc != we.cyc) begin
            errors++;
            $display("FAIL word_strobe: got word=%h idx=%0d cyc=%0d, expected word=%h idx=%0d cyc=%0d",
                     word, word_idx, cyc, we.w, we.idx, we.cyc);
          end
        end
      end
      if (sync_err !== 1'b0) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL sync_err: unexpected pulse (value %b) at cyc %0d", sync_err, cyc);
        end else begin
          sc = sq.pop_front();
          if (cyc != sc) begin
            errors++;
            $display("FAIL sync_err: pulse at cyc %0d, expected cyc %0d", cyc, sc);
          end
        end
      end
      if (locked !== prev_locked) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL locked_change: unexpected change to %b at cyc %0d", locked, cyc);
        end else begin
          le = lq.pop_front();
          if (locked !== le.val || cyc != le.cyc) begin
            errors++;
            $display("FAIL locked_change: got %b at cyc %0d, expected %b at cyc %0d",
                     locked, cyc, le.val, le.cyc);
          end
        end
      end
      prev_locked = locked;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one word MSB first; expectations tied to the LSB edge.
  // emit: expected slot index (0 = no strobe); lev: -1 none, else new locked value.
  task automatic send_word(input logic [11:0] w, input int emit, input bit serr,
                           input int lev, input bit rst_lsb);
    for (int i = 11; i >= 0; i--) begin
      @(negedge clk);
      #1;
      din   = w[i];
      reset = (i == 0) ? rst_lsb : 1'b0;
      if (i == 0) begin
        if (emit > 0) wq.push_back('{cyc + 1, w, 8'(emit)});
        if (serr)     sq.push_back(cyc + 1);
        if (lev >= 0) lq.push_back('{cyc + 1, lev[0]});
      end
    end
  endtask

  task automatic frame(input logic [11:0] s, input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input bit emit, input bit serr, input int lev);
    send_word(s, 0, serr, lev, 1'b0);
    send_word(a, emit ? 1 : 0, 1'b0, -1, 1'b0);
    send_word(b, emit ? 2 : 0, 1'b0, -1, 1'b0);
    send_word(c, emit ? 3 : 0, 1'b0, -1, 1'b0);
  endtask

  initial begin
    // Reset with toggling data
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1 din = ~din;
    end
    @(negedge clk);
    chk("reset_word", 32'(word), 32'h0);
    chk("reset_word_valid", 32'(word_valid), 32'h0);
    chk("reset_word_idx", 32'(word_idx), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    chk("reset_sync_err", 32'(sync_err), 32'h0);
    prev_locked = 1'b0;
    mon_en = 1'b1;

    // Acquisition, entering at bit offset 5 of a frame (remaining 7 sync bits are 0)
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      din   = 1'b0;
      reset = 1'b0;
    end
    send_word(12'hABC, 0, 1'b0, -1, 1'b0);
    send_word(12'h123, 0, 1'b0, -1, 1'b0);
    send_word(12'hFFF, 0, 1'b0, -1, 1'b0);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b0, 1'b0, -1);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b1, 1'b0, 1);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b1, 1'b0, -1);

    // Single miss: flywheel keeps lock and payload
    frame(12'h0FF, 12'hABC, 12'h123, 12'hFFF, 1'b1, 1'b1, -1);
    frame(12'h100, 12'h5A5, 12'h3C3, 12'h001, 1'b1, 1'b0, -1);

    // Loss of lock after two consecutive misses, then re-acquire
    frame(12'h000, 12'hABC, 12'h123, 12'hFFF, 1'b1, 1'b1, -1);
    frame(12'h000, 12'hABC, 12'h123, 12'hFFF, 1'b0, 1'b1, 0);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b0, 1'b0, -1);
    frame(12'h100, 12'h456, 12'h789, 12'hFFF, 1'b1, 1'b0, 1);

    // Reset on a payload LSB edge while locked; hunting then sees a false sync
    send_word(12'h100, 0, 1'b0, -1, 1'b0);
    send_word(12'hABC, 0, 1'b0, 0, 1'b1);
    send_word(12'h100, 0, 1'b0, -1, 1'b0);
    send_word(12'hFFF, 0, 1'b0, -1, 1'b0);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b0, 1'b0, -1);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b0, 1'b0, -1);
    frame(12'h100, 12'hABC, 12'h123, 12'hFFF, 1'b1, 1'b0, 1);
    frame(12'h100, 12'hABC, 12'h100, 12'hFFF, 1'b1, 1'b0, -1);

    // Short tail, well before the next sync boundary
    repeat (3) begin
      @(negedge clk);
      #1 din = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("final_locked", 32'(locked), 32'h1);
    chk("pending_words", 32'(wq.size()), 32'h0);
    chk("pending_sync_err", 32'(sq.size()), 32'h0);
    chk("pending_lock_events", 32'(lq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
